// File: rtl/matbi_multi_tick_gen.sv
// matbi_multi_tick_gen: P_NUM_CH independent programmable periodic/one-shot tick channels
module matbi_multi_tick_gen #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_NUM_CH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [P_NUM_CH-1:0]             i_run_en,
  input  logic [P_NUM_CH-1:0]             i_mode,
  input  logic [P_NUM_CH-1:0]             i_clear,
  input  logic [P_NUM_CH*P_COUNT_BIT-1:0] i_period,
  output logic [P_NUM_CH-1:0]             o_tick,
  output logic [P_NUM_CH-1:0]             o_busy,
  output logic [P_NUM_CH-1:0]             o_cfg_err
);
  localparam logic [P_COUNT_BIT-1:0] one = 1;
  for (genvar g = 0; g < P_NUM_CH; g++) begin : g_ch
    logic [P_COUNT_BIT-1:0] per, cnt_q, cnt_d;
    logic tick_q, tick_d, done_q, done_d, cnt_en, term;
    always_comb begin
      per    = i_period[g*P_COUNT_BIT +: P_COUNT_BIT];
      cnt_en = i_run_en[g] & (per != '0) & ~(i_mode[g] & done_q);
      term   = cnt_q >= (per - one);
      cnt_d  = (i_clear[g] | (per == '0)) ? '0 : ~i_run_en[g] ? cnt_q : (~cnt_en | term) ? '0 : cnt_q + one;
      tick_d = ~i_clear[g] & cnt_en & term;
      done_d = ~i_clear[g] & (done_q | (cnt_en & i_mode[g] & term));
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        done_q <= done_d;
      end
    end
    assign o_tick[g]    = tick_q;
    assign o_busy[g]    = cnt_en;
    assign o_cfg_err[g] = (per == '0);
  end
endmodule

// File: tb/tb_matbi_multi_tick_gen.sv
// tb_matbi_multi_tick_gen: directed and randomized check of matbi_multi_tick_gen against a behavioural model
module tb_matbi_multi_tick_gen;
  localparam int W = 30;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] run_en = '0, mode = '0, clr = '0;
  logic [N*W-1:0] period = '0;
  logic [N-1:0] tick, busy, cfg_err;
  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;
  longint m_cnt[N];
  bit m_tick[N], m_done[N];
  int tick_cnt[N];
  logic [31:0] m;
  always #5 clk = ~clk;
  matbi_multi_tick_gen #(.P_COUNT_BIT(W), .P_NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .i_run_en(run_en), .i_mode(mode), .i_clear(clr),
    .i_period(period), .o_tick(tick), .o_busy(busy), .o_cfg_err(cfg_err)
  );
  function automatic longint per_of(int k);
    return longint'(period[k*W +: W]);
  endfunction
  // Reference: elapsed enabled clocks since last wrap; tick when this edge completes the period.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      longint p;
      p = per_of(k);
      if (reset) begin
        m_cnt[k] = 0; m_tick[k] = 0; m_done[k] = 0;
      end else if (clr[k]) begin
        m_cnt[k] = 0; m_tick[k] = 0; m_done[k] = 0;
      end else if (p == 0) begin
        m_cnt[k] = 0; m_tick[k] = 0;
      end else if (!run_en[k]) begin
        m_tick[k] = 0;
      end else if (mode[k] && m_done[k]) begin
        m_cnt[k] = 0; m_tick[k] = 0;
      end else if (m_cnt[k] + 1 >= p) begin
        m_cnt[k] = 0; m_tick[k] = 1;
        if (mode[k]) m_done[k] = 1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1; m_tick[k] = 0;
      end
    end
  end
  always @(negedge clk) begin
    logic [N-1:0] e_tick, e_busy, e_err;
    for (int k = 0; k < N; k++) begin
      e_tick[k] = m_tick[k];
      e_err[k]  = per_of(k) == 0;
      e_busy[k] = run_en[k] && per_of(k) != 0 && !(mode[k] && m_done[k]);
      if (tick[k] === 1'b1) tick_cnt[k]++;
    end
    if (chk_on) begin
      vectors += 3;
      if (tick !== e_tick) begin
        miscompares++;
        $display("FAIL o_tick t=%0t got %b exp %b", $time, tick, e_tick);
      end
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL o_busy t=%0t got %b exp %b", $time, busy, e_busy);
      end
      if (cfg_err !== e_err) begin
        miscompares++;
        $display("FAIL o_cfg_err t=%0t got %b exp %b", $time, cfg_err, e_err);
      end
    end
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_per(int k, int v);
    period[k*W +: W] = W'(v);
  endtask
  task automatic do_reset();
    reset = 1'b1; run_en = '0; mode = '0; clr = '0; period = '0;
    step(1);
    reset = 1'b0;
  endtask
  task automatic chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask
  task automatic rec(int ch, int n, output logic [31:0] mk);
    mk = '0;
    for (int i = 0; i < n; i++) begin
      step(1);
      mk[i] = tick[ch];
    end
  endtask
  initial begin
    do_reset();
    chk_on = 1'b1;
    chk("reset_tick", longint'(tick), 0);
    set_per(0, 5); run_en[0] = 1'b1;
    rec(0, 20, m);
    chk("p5_ticks", longint'(m), 32'h84210);
    do_reset();
    set_per(1, 4); mode[1] = 1'b1; run_en[1] = 1'b1;
    rec(1, 10, m);
    chk("oneshot_ticks", longint'(m), 32'h008);
    chk("oneshot_busy", longint'(busy[1]), 0);
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    chk("oneshot_clr_busy", longint'(busy[1]), 1);
    rec(1, 6, m);
    chk("oneshot_rearm", longint'(m), 32'h08);
    do_reset();
    set_per(0, 10); run_en[0] = 1'b1;
    step(7);
    set_per(0, 3);
    rec(0, 7, m);
    chk("shrink", longint'(m), 32'h49);
    do_reset();
    run_en[2] = 1'b1;
    step(1);
    chk("p0_err", longint'(cfg_err[2]), 1);
    chk("p0_busy", longint'(busy[2]), 0);
    rec(2, 5, m);
    chk("p0_ticks", longint'(m), 0);
    set_per(2, 1);
    rec(2, 5, m);
    chk("p1_ticks", longint'(m), 32'h1f);
    chk("p1_err", longint'(cfg_err[2]), 0);
    do_reset();
    set_per(0, 5); run_en[0] = 1'b1;
    step(3);
    run_en[0] = 1'b0;
    rec(0, 6, m);
    chk("disabled", longint'(m), 0);
    run_en[0] = 1'b1;
    rec(0, 3, m);
    chk("reenable", longint'(m), 32'h2);
    step(3);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    chk("clr_on_term", longint'(tick[0]), 0);
    rec(0, 5, m);
    chk("after_clr", longint'(m), 32'h10);
    do_reset();
    set_per(0, 2); set_per(1, 3); set_per(2, 5); set_per(3, 7);
    run_en = '1;
    for (int k = 0; k < N; k++) tick_cnt[k] = 0;
    step(210);
    @(negedge clk);
    #1;
    chk("cnt_ch0", tick_cnt[0], 105);
    chk("cnt_ch1", tick_cnt[1], 70);
    chk("cnt_ch2", tick_cnt[2], 42);
    chk("cnt_ch3", tick_cnt[3], 30);
    step(4);
    reset = 1'b1;
    step(1);
    chk("midrun_reset_tick", longint'(tick), 0);
    reset = 1'b0;
    do_reset();
    for (int k = 0; k < N; k++) set_per(k, $urandom_range(1, 9));
    run_en = '1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 39) == 0) set_per(k, $urandom_range(0, 12));
        if ($urandom_range(0, 63) == 0) mode[k] = ~mode[k];
        run_en[k] = $urandom_range(0, 7) != 0;
        clr[k] = $urandom_range(0, 19) == 0;
      end
      reset = $urandom_range(0, 299) == 0;
      step(1);
    end
    reset = 1'b0; clr = '0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
